// File: rtl/cpu_sequencer_pkg.sv
// Shared encodings for the nemesys control sequencer: FSM states, opcodes,
// branch condition codes and flag bit positions.
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH      = 3'd1,
        ST_DECODE     = 3'd2,
        ST_EXECUTE    = 3'd3,
        ST_WRITE_BACK = 3'd4,
        ST_HALT       = 3'd5
    } state_t;

    // Opcode lives in inst[31:27]; anything not listed below writes back.
    localparam logic [4:0] OP_ADD = 5'h00;
    localparam logic [4:0] OP_BR  = 5'h18;
    localparam logic [4:0] OP_CMP = 5'h19;
    localparam logic [4:0] OP_HLT = 5'h1F;

    localparam logic [2:0] COND_AL  = 3'd0;
    localparam logic [2:0] COND_EQ  = 3'd1;
    localparam logic [2:0] COND_NE  = 3'd2;
    localparam logic [2:0] COND_LT  = 3'd3;
    localparam logic [2:0] COND_GE  = 3'd4;
    localparam logic [2:0] COND_LTU = 3'd5;
    localparam logic [2:0] COND_GEU = 3'd6;
    localparam logic [2:0] COND_NV  = 3'd7;

    // Flag register layout {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cpu_sequencer_branch_cond_eval.sv
// Combinational branch condition evaluation against the {N,Z,C,V} flag register.
module branch_cond_eval
    import cpu_sequencer_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [3:0] flags,
    output logic       take
);

    logic lt;
    assign lt = flags[FLAG_N] ^ flags[FLAG_V];

    always_comb begin
        take = 1'b0;
        case (cond)
            COND_AL:  take = 1'b1;
            COND_EQ:  take = flags[FLAG_Z];
            COND_NE:  take = !flags[FLAG_Z];
            COND_LT:  take = lt;
            COND_GE:  take = !lt;
            COND_LTU: take = !flags[FLAG_C];
            COND_GEU: take = flags[FLAG_C];
            COND_NV:  take = 1'b0;
            default:  take = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: handshaked fetch with timeout, decode/execute/
// write-back pacing, CMP flag register and retired-instruction counter.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int CNT_W         = 32,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_data,
    output logic [WIDTH-1:0] inst,
    input  logic [3:0]       alu_flags,
    output logic [3:0]       flags,
    output logic             pc_enable,
    output logic             take_branch,
    output logic             rf_write_enable,
    output logic [2:0]       state_out,
    output logic             halted,
    output logic             fetch_fault,
    output logic [CNT_W-1:0] retired
);

    localparam logic [7:0] WAIT_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic [4:0] opcode;
    logic       is_br, is_cmp, is_hlt, cond_true;

    assign opcode    = inst[31:27];
    assign is_br     = (opcode == OP_BR);
    assign is_cmp    = (opcode == OP_CMP);
    assign is_hlt    = (opcode == OP_HLT);
    assign state_out = state;

    // Sees the flag register as it stands, so a CMP in the previous slot is visible.
    branch_cond_eval u_cond (
        .cond  (inst[23:21]),
        .flags (flags),
        .take  (cond_true)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            inst            <= '0;
            flags           <= '0;
            retired         <= '0;
            fetch_fault     <= 1'b0;
            wait_cnt        <= '0;
            imem_req        <= 1'b0;
            pc_enable       <= 1'b0;
            take_branch     <= 1'b0;
            rf_write_enable <= 1'b0;
            halted          <= 1'b0;
        end else begin
            pc_enable       <= 1'b0;
            take_branch     <= 1'b0;
            rf_write_enable <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state    <= ST_FETCH;
                        imem_req <= 1'b1;
                        wait_cnt <= '0;
                    end
                end
                ST_FETCH: begin
                    // Ack wins over timeout on the last permitted wait cycle.
                    if (imem_ack) begin
                        inst     <= imem_data;
                        imem_req <= 1'b0;
                        state    <= ST_DECODE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        fetch_fault <= 1'b1;
                        halted      <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= ST_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_DECODE: state <= ST_EXECUTE;
                ST_EXECUTE: begin
                    if (is_cmp) flags <= alu_flags;
                    // Pulses are staged here so they appear during WRITE_BACK.
                    pc_enable       <= 1'b1;
                    take_branch     <= is_br && cond_true;
                    rf_write_enable <= !(is_br || is_cmp || is_hlt);
                    state           <= ST_WRITE_BACK;
                end
                ST_WRITE_BACK: begin
                    retired <= retired + CNT_W'(1);
                    if (is_hlt) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end else if (run) begin
                        state    <= ST_FETCH;
                        imem_req <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer; a second CNT_W=4 instance shares stimulus
// to exercise counter wrap.
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset, run, imem_ack;
    logic [31:0] imem_data;
    logic [3:0]  alu_flags;

    logic        imem_req, pc_enable, take_branch, rf_write_enable, halted, fetch_fault;
    logic [31:0] inst, retired;
    logic [3:0]  flags;
    logic [2:0]  state_out;

    logic        imem_req_4, pc_enable_4, take_branch_4, rf_write_enable_4, halted_4, fetch_fault_4;
    logic [31:0] inst_4;
    logic [3:0]  flags_4, retired_4;
    logic [2:0]  state_out_4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.WIDTH(32), .CNT_W(32), .FETCH_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .run(run), .imem_req(imem_req), .imem_ack(imem_ack),
        .imem_data(imem_data), .inst(inst), .alu_flags(alu_flags), .flags(flags),
        .pc_enable(pc_enable), .take_branch(take_branch), .rf_write_enable(rf_write_enable),
        .state_out(state_out), .halted(halted), .fetch_fault(fetch_fault), .retired(retired)
    );

    cpu_sequencer #(.WIDTH(32), .CNT_W(4), .FETCH_TIMEOUT(15)) dut4 (
        .clk(clk), .reset(reset), .run(run), .imem_req(imem_req_4), .imem_ack(imem_ack),
        .imem_data(imem_data), .inst(inst_4), .alu_flags(alu_flags), .flags(flags_4),
        .pc_enable(pc_enable_4), .take_branch(take_branch_4), .rf_write_enable(rf_write_enable_4),
        .state_out(state_out_4), .halted(halted_4), .fetch_fault(fetch_fault_4), .retired(retired_4)
    );

    localparam logic [31:0] W_ADD  = 32'h0000_1234;
    localparam logic [31:0] W_ADD2 = 32'h0ABC_0042;
    localparam logic [31:0] W_CMP  = 32'hC800_0000;  // OP_CMP << 27
    localparam logic [31:0] W_HLT  = 32'hF800_0000;  // OP_HLT << 27

    function automatic logic [31:0] br_word(input logic [2:0] c);
        br_word = (32'(OP_BR) << 27) | (32'(c) << 21);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_data = '0; alu_flags = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        imem_ack = 1'b1; imem_data = W_ADD;
        do_reset();
        imem_ack = 1'b1; imem_data = W_ADD;
        tick();
        checks++; if (state_out !== 3'(ST_IDLE)) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state_out, ST_IDLE); end
        checks++; if (inst !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=0", inst); end
        checks++; if (flags !== 4'h0 || retired !== 32'h0) begin failures++; $display("FAIL reset_flags_retired got=%h/%0d exp=0/0", flags, retired); end
        checks++; if ({imem_req, pc_enable, take_branch, rf_write_enable, halted, fetch_fault} !== 6'b0) begin
            failures++; $display("FAIL reset_outputs got=%b exp=000000", {imem_req, pc_enable, take_branch, rf_write_enable, halted, fetch_fault}); end
        imem_ack = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        run = 1'b1; imem_ack = 1'b1; imem_data = W_ADD;
        tick();
        checks++; if (state_out !== 3'(ST_FETCH) || imem_req !== 1'b1) begin failures++; $display("FAIL basic_fetch got=%0d/%b exp=1/1", state_out, imem_req); end
        tick();
        checks++; if (inst !== W_ADD || imem_req !== 1'b0) begin failures++; $display("FAIL basic_latch got=%h/%b exp=%h/0", inst, imem_req, W_ADD); end
        tick();
        checks++; if (rf_write_enable !== 1'b0) begin failures++; $display("FAIL basic_early_we got=%b exp=0", rf_write_enable); end
        tick();
        checks++; if (rf_write_enable !== 1'b1 || pc_enable !== 1'b1 || take_branch !== 1'b0) begin
            failures++; $display("FAIL basic_wb got=%b%b%b exp=110", rf_write_enable, pc_enable, take_branch); end
        tick();
        checks++; if (retired !== 32'd1 || rf_write_enable !== 1'b0 || state_out !== 3'(ST_FETCH)) begin
            failures++; $display("FAIL basic_retire got=%0d/%b/%0d exp=1/0/1", retired, rf_write_enable, state_out); end
        tick(); tick(); tick();
        checks++; if (rf_write_enable !== 1'b1) begin failures++; $display("FAIL basic_period got=%b exp=1", rf_write_enable); end
        run = 1'b0;
        tick();
        checks++; if (retired !== 32'd2 || state_out !== 3'(ST_IDLE)) begin failures++; $display("FAIL basic_idle got=%0d/%0d exp=2/0", retired, state_out); end
        imem_ack = 1'b0;
    endtask

    task automatic test_wait_states();
        int req_cnt;
        do_reset();
        run = 1'b1; imem_ack = 1'b0; imem_data = 32'hDEAD_BEEF;
        req_cnt = 0;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            tick();
            if (imem_req === 1'b1) req_cnt++;
            if (cyc == 5) begin
                checks++; if (inst !== W_ADD2) begin failures++; $display("FAIL wait_latch got=%h exp=%h", inst, W_ADD2); end
            end
            if (cyc == 4) begin imem_ack = 1'b1; imem_data = W_ADD2; end
            else begin imem_ack = 1'b0; imem_data = 32'hDEAD_BEEF; end
        end
        run = 1'b0;
        checks++; if (req_cnt !== 4) begin failures++; $display("FAIL wait_req_cycles got=%0d exp=4", req_cnt); end
        checks++; if (state_out !== 3'(ST_WRITE_BACK) || rf_write_enable !== 1'b1) begin
            failures++; $display("FAIL wait_wb7 got=%0d/%b exp=4/1", state_out, rf_write_enable); end
        checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL wait_nofault got=%b exp=0", fetch_fault); end
    endtask

    task automatic test_timeout();
        do_reset();
        run = 1'b1; imem_ack = 1'b0;
        for (int cyc = 1; cyc <= 15; cyc++) tick();
        checks++; if (state_out !== 3'(ST_FETCH) || fetch_fault !== 1'b0) begin
            failures++; $display("FAIL timeout_c15 got=%0d/%b exp=1/0", state_out, fetch_fault); end
        tick();
        checks++; if (fetch_fault !== 1'b1 || halted !== 1'b1 || state_out !== 3'(ST_HALT) || imem_req !== 1'b0) begin
            failures++; $display("FAIL timeout_fault got=%b%b/%0d/%b exp=11/5/0", fetch_fault, halted, state_out, imem_req); end
        do_reset();
        run = 1'b1; imem_data = W_ADD;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            tick();
            if (cyc == 15) imem_ack = 1'b1;
        end
        tick();
        imem_ack = 1'b0; run = 1'b0;
        checks++; if (fetch_fault !== 1'b0 || halted !== 1'b0 || state_out !== 3'(ST_DECODE)) begin
            failures++; $display("FAIL timeout_late_ack got=%b%b/%0d exp=00/2", fetch_fault, halted, state_out); end
    endtask

    task automatic test_branch();
        logic [31:0] w [10];
        logic [3:0]  af [10];
        logic [3:0]  ef [10];
        logic        et [10];
        w[0] = W_CMP;            af[0] = 4'b0100; ef[0] = 4'b0100; et[0] = 1'b0;
        w[1] = br_word(COND_EQ);  af[1] = 4'b1011; ef[1] = 4'b0100; et[1] = 1'b1;
        w[2] = br_word(COND_NE);  af[2] = 4'b1011; ef[2] = 4'b0100; et[2] = 1'b0;
        w[3] = W_CMP;            af[3] = 4'b1000; ef[3] = 4'b1000; et[3] = 1'b0;
        w[4] = br_word(COND_LT);  af[4] = 4'b0011; ef[4] = 4'b1000; et[4] = 1'b1;
        w[5] = br_word(COND_GE);  af[5] = 4'b0011; ef[5] = 4'b1000; et[5] = 1'b0;
        w[6] = br_word(COND_GEU); af[6] = 4'b0011; ef[6] = 4'b1000; et[6] = 1'b0;
        w[7] = br_word(COND_LTU); af[7] = 4'b0011; ef[7] = 4'b1000; et[7] = 1'b1;
        w[8] = br_word(COND_AL);  af[8] = 4'b0011; ef[8] = 4'b1000; et[8] = 1'b1;
        w[9] = br_word(COND_NV);  af[9] = 4'b0011; ef[9] = 4'b1000; et[9] = 1'b0;
        do_reset();
        run = 1'b1; imem_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            imem_data = w[i]; alu_flags = af[i];
            tick(); tick(); tick(); tick();
            checks++; if (take_branch !== et[i] || pc_enable !== 1'b1 || rf_write_enable !== 1'b0) begin
                failures++; $display("FAIL branch_%0d take/pc/we got=%b%b%b exp=%b10", i, take_branch, pc_enable, rf_write_enable, et[i]); end
            checks++; if (flags !== ef[i]) begin failures++; $display("FAIL branch_%0d_flags got=%b exp=%b", i, flags, ef[i]); end
        end
        run = 1'b0; imem_ack = 1'b0;
        tick();
    endtask

    task automatic test_halt();
        do_reset();
        run = 1'b1; imem_ack = 1'b1; imem_data = W_HLT;
        tick(); tick(); tick(); tick();
        checks++; if (pc_enable !== 1'b1 || take_branch !== 1'b0 || rf_write_enable !== 1'b0) begin
            failures++; $display("FAIL halt_wb got=%b%b%b exp=100", pc_enable, take_branch, rf_write_enable); end
        imem_data = W_ADD;
        tick();
        checks++; if (halted !== 1'b1 || retired !== 32'd1 || state_out !== 3'(ST_HALT)) begin
            failures++; $display("FAIL halt_enter got=%b/%0d/%0d exp=1/1/5", halted, retired, state_out); end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (imem_req !== 1'b0 || pc_enable !== 1'b0 || state_out !== 3'(ST_HALT) || retired !== 32'd1) begin
                failures++; $display("FAIL halt_stick_%0d got=%b%b/%0d/%0d exp=00/5/1", i, imem_req, pc_enable, state_out, retired); end
        end
        run = 1'b0; imem_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        run = 1'b1; imem_ack = 1'b1; imem_data = W_ADD;
        tick(); tick(); tick(); tick();
        imem_ack = 1'b0;
        tick();
        checks++; if (retired !== 32'd1 || state_out !== 3'(ST_FETCH)) begin
            failures++; $display("FAIL midrst_pre got=%0d/%0d exp=1/1", retired, state_out); end
        reset = 1'b1; imem_ack = 1'b1; imem_data = W_ADD2;
        tick();
        checks++; if (state_out !== 3'(ST_IDLE) || inst !== 32'h0 || retired !== 32'd0 || imem_req !== 1'b0) begin
            failures++; $display("FAIL midrst_reset got=%0d/%h/%0d/%b exp=0/0/0/0", state_out, inst, retired, imem_req); end
        reset = 1'b0; run = 1'b0;
        tick();
        checks++; if (state_out !== 3'(ST_IDLE) || inst !== 32'h0) begin
            failures++; $display("FAIL midrst_late_ack got=%0d/%h exp=0/0", state_out, inst); end
        imem_ack = 1'b0;
    endtask

    task automatic test_back_to_back_wrap();
        do_reset();
        run = 1'b1; imem_ack = 1'b1; imem_data = W_ADD;
        for (int c = 1; c <= 61; c++) tick();
        checks++; if (retired_4 !== 4'd15) begin failures++; $display("FAIL wrap_15 got=%0d exp=15", retired_4); end
        for (int c = 62; c <= 65; c++) tick();
        checks++; if (retired_4 !== 4'd0) begin failures++; $display("FAIL wrap_16 got=%0d exp=0", retired_4); end
        checks++; if (retired !== 32'd16) begin failures++; $display("FAIL b2b_count got=%0d exp=16", retired); end
        run = 1'b0; imem_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_data = '0; alu_flags = '0;
        test_reset();
        test_basic();
        test_wait_states();
        test_timeout();
        test_branch();
        test_halt();
        test_reset_mid();
        test_back_to_back_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
